// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave cook-cycle controller:
// state encoding, BCD digit limits and the quick-start time constants.
package mw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } mmss_t;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    localparam int         QUICK_ADD_SECS = 30;
    localparam logic [3:0] QUICK_ADD_TENS = 4'(QUICK_ADD_SECS / 10);
    localparam mmss_t      QUICK_TIME     = '{4'd0, QUICK_ADD_TENS, 4'd0};
    localparam mmss_t      SAT_TIME       = '{UNITS_MAX, TENS_MAX, UNITS_MAX};
    localparam mmss_t      ONE_SECOND     = '{4'd0, 4'd0, 4'd1};

    function automatic logic [3:0] clamp_bcd(input logic [3:0] digit, input logic [3:0] max);
        return (digit > max) ? max : digit;
    endfunction

endpackage

// File: rtl/bcd_countdown.sv
// m:ss BCD time register: clamped load, quick-start load, one-second decrement,
// 30-second add (saturating at 9:59) and clear; flags zero and one-second states.
module bcd_countdown
    import mw_pkg::*;
(
    input  logic       clk,
    input  logic       clearn,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_sec_ones,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_min_ones,
    input  logic       quick_load,
    input  logic       dec,
    input  logic       add30,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       is_zero,
    output logic       is_one
);

    mmss_t      time_q;
    mmss_t      dec_time;
    mmss_t      time_d;
    logic [3:0] tens_sum;

    assign is_zero  = (time_q == '0);
    assign is_one   = (time_q == ONE_SECOND);
    assign sec_ones = time_q.sec_ones;
    assign sec_tens = time_q.sec_tens;
    assign min_ones = time_q.min_ones;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        dec_time = time_q;
        if (dec && !is_zero) begin
            if (time_q.sec_ones != 4'd0) begin
                dec_time.sec_ones = time_q.sec_ones - 4'd1;
            end else begin
                dec_time.sec_ones = UNITS_MAX;
                if (time_q.sec_tens != 4'd0) begin
                    dec_time.sec_tens = time_q.sec_tens - 4'd1;
                end else begin
                    dec_time.sec_tens = TENS_MAX;
                    dec_time.min_ones = time_q.min_ones - 4'd1;
                end
            end
        end

        // The add is applied on top of the decremented value: tick first, then add.
        tens_sum = dec_time.sec_tens + QUICK_ADD_TENS;
        time_d   = dec_time;
        if (add30) begin
            if (tens_sum <= TENS_MAX) begin
                time_d.sec_tens = tens_sum;
            end else if (dec_time.min_ones == UNITS_MAX) begin
                time_d = SAT_TIME;
            end else begin
                time_d.sec_tens = tens_sum - TENS_MAX - 4'd1;
                time_d.min_ones = dec_time.min_ones + 4'd1;
            end
        end

        if (clear) begin
            time_d = '0;
        end else if (load) begin
            time_d = '{clamp_bcd(load_min_ones, UNITS_MAX),
                       clamp_bcd(load_sec_tens, TENS_MAX),
                       clamp_bcd(load_sec_ones, UNITS_MAX)};
        end else if (quick_load) begin
            time_d = QUICK_TIME;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

endmodule

// File: rtl/microwave_controller.sv
// Cook-cycle sequencer: button press detection, IDLE/SET/COOK/PAUSE/DONE FSM,
// DONE dwell counter and magnetron enable. Optional MICROWAVE_QUICK_START_EN adds quick start / +30 s.
module microwave_controller
    import mw_pkg::*;
#(
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       tick,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       loadn,
    input  logic [3:0] units_of_seconds,
    input  logic [3:0] tens_of_seconds,
    input  logic [3:0] units_of_minutes,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state
);

    state_t     cur_state;
    state_t     nxt_state;
    logic       start_q, start_prev, stop_q, stop_prev;
    logic       start_press, stop_press;
    logic [7:0] done_cnt;
    logic       done_last;
    logic       load_nonzero;
    logic       cnt_clear, cnt_load, cnt_quick, cnt_dec, cnt_add;
    logic       is_zero, is_one;

    assign state        = cur_state;
    assign start_press  = start_prev & ~start_q;
    assign stop_press   = stop_prev & ~stop_q;
    assign done_last    = (DONE_TICKS != 0) && (int'(done_cnt) == DONE_TICKS - 1);
    // Clamping never turns a nonzero digit into zero, so the raw digits decide.
    assign load_nonzero = |{units_of_seconds, tens_of_seconds, units_of_minutes};

    always_comb begin
        nxt_state = cur_state;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_quick = 1'b0;
        cnt_dec   = 1'b0;
        cnt_add   = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (!loadn) begin
                    cnt_load  = 1'b1;
                    nxt_state = load_nonzero ? ST_SET : ST_IDLE;
                end
`ifdef MICROWAVE_QUICK_START_EN
                else if (start_press && door_closed) begin
                    cnt_quick = 1'b1;
                    nxt_state = ST_COOK;
                end
`endif
            end
            ST_SET: begin
                if (stop_press) begin
                    cnt_clear = 1'b1;
                    nxt_state = ST_IDLE;
                end else if (start_press && door_closed) begin
                    nxt_state = ST_COOK;
                end else if (!loadn) begin
                    cnt_load  = 1'b1;
                    nxt_state = load_nonzero ? ST_SET : ST_IDLE;
                end
            end
            ST_COOK: begin
                // Door open and stop both win over a same-cycle tick, which is dropped.
                if (!door_closed || stop_press) begin
                    nxt_state = ST_PAUSE;
                end else begin
`ifdef MICROWAVE_QUICK_START_EN
                    cnt_add = start_press;
`endif
                    if (tick) begin
                        cnt_dec = 1'b1;
                        if (is_one && !cnt_add) begin
                            nxt_state = ST_DONE;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_press) begin
                    cnt_clear = 1'b1;
                    nxt_state = ST_IDLE;
                end else if (start_press && door_closed) begin
                    nxt_state = ST_COOK;
                end
            end
            ST_DONE: begin
                if (start_press || stop_press) begin
                    cnt_clear = 1'b1;
                    nxt_state = ST_IDLE;
                end else if (tick && done_last) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: begin
                cnt_clear = 1'b1;
                nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            cur_state  <= ST_IDLE;
            start_q    <= 1'b1;
            start_prev <= 1'b1;
            stop_q     <= 1'b1;
            stop_prev  <= 1'b1;
            done_cnt   <= '0;
            mag_on     <= 1'b0;
            done       <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            start_q    <= startn;
            start_prev <= start_q;
            stop_q     <= stopn;
            stop_prev  <= stop_q;
            mag_on     <= (nxt_state == ST_COOK);
            done       <= (nxt_state == ST_DONE);
            if (nxt_state != ST_DONE) begin
                done_cnt <= '0;
            end else if (cur_state == ST_DONE && tick) begin
                done_cnt <= done_cnt + 8'd1;
            end
        end
    end

    bcd_countdown u_countdown (
        .clk           (clk),
        .clearn        (clearn),
        .clear         (cnt_clear),
        .load          (cnt_load),
        .load_sec_ones (units_of_seconds),
        .load_sec_tens (tens_of_seconds),
        .load_min_ones (units_of_minutes),
        .quick_load    (cnt_quick),
        .dec           (cnt_dec),
        .add30         (cnt_add),
        .sec_ones      (sec_ones),
        .sec_tens      (sec_tens),
        .min_ones      (min_ones),
        .is_zero       (is_zero),
        .is_one        (is_one)
    );

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller; quick-start scenarios run when
// MICROWAVE_QUICK_START_EN is defined for the build.
module tb_microwave_controller;

    logic       clk;
    logic       clearn;
    logic       tick;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       loadn;
    logic [3:0] units_of_seconds;
    logic [3:0] tens_of_seconds;
    logic [3:0] units_of_minutes;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic       mag_on;
    logic       done;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_COOK = 3'd2, S_PAUSE = 3'd3, S_DONE = 3'd4;

    microwave_controller #(.DONE_TICKS(3)) dut (
        .clk              (clk),
        .clearn           (clearn),
        .tick             (tick),
        .startn           (startn),
        .stopn            (stopn),
        .door_closed      (door_closed),
        .loadn            (loadn),
        .units_of_seconds (units_of_seconds),
        .tens_of_seconds  (tens_of_seconds),
        .units_of_minutes (units_of_minutes),
        .sec_ones         (sec_ones),
        .sec_tens         (sec_tens),
        .min_ones         (min_ones),
        .mag_on           (mag_on),
        .done             (done),
        .state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_start();
        startn = 1'b0;
        step(1);
        startn = 1'b1;
        step(1);
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        step(1);
        stopn = 1'b1;
        step(1);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
    endtask

    task automatic load_time(input logic [3:0] m, input logic [3:0] t, input logic [3:0] u);
        units_of_minutes = m;
        tens_of_seconds  = t;
        units_of_seconds = u;
        loadn = 1'b0;
        step(1);
        loadn = 1'b1;
    endtask

    // Compares state, time (BCD m:ss packed as 12 bits), mag_on and done in one go.
    task automatic expect_all(input string name, input logic [2:0] exp_state,
                              input logic [11:0] exp_time, input logic exp_mag, input logic exp_done);
        checks++;
        if ({state, min_ones, sec_tens, sec_ones, mag_on, done} !== {exp_state, exp_time, exp_mag, exp_done}) begin
            errors++;
            $display("FAIL %s: state=%0d time=%h mag_on=%b done=%b, expected state=%0d time=%h mag_on=%b done=%b",
                     name, state, {min_ones, sec_tens, sec_ones}, mag_on, done,
                     exp_state, exp_time, exp_mag, exp_done);
        end
    endtask

    task automatic test_reset();
        clearn = 1'b0;
        step(2);
        expect_all("reset_held", S_IDLE, 12'h000, 1'b0, 1'b0);
        clearn = 1'b1;
        step(2);
        expect_all("reset_released", S_IDLE, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_full_countdown();
        int s;
        logic [11:0] exp_time;
        load_time(4'd1, 4'd3, 4'd0);
        expect_all("load_130", S_SET, 12'h130, 1'b0, 1'b0);
        press_start();
        expect_all("start_130", S_COOK, 12'h130, 1'b1, 1'b0);
        for (int i = 1; i <= 90; i++) begin
            do_tick();
            s = 90 - i;
            exp_time = {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
            if (s > 0) expect_all("countdown", S_COOK, exp_time, 1'b1, 1'b0);
            else       expect_all("countdown_end", S_DONE, exp_time, 1'b0, 1'b1);
        end
        do_tick();
        do_tick();
        expect_all("done_dwell_2", S_DONE, 12'h000, 1'b0, 1'b1);
        do_tick();
        expect_all("done_auto_idle", S_IDLE, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_door_pause();
        load_time(4'd0, 4'd0, 4'd5);
        press_start();
        do_tick();
        do_tick();
        expect_all("pause_pre_open", S_COOK, 12'h003, 1'b1, 1'b0);
        // Door opens on the same edge as a tick: the tick must be dropped.
        door_closed = 1'b0;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        expect_all("door_open_pause", S_PAUSE, 12'h003, 1'b0, 1'b0);
        do_tick();
        expect_all("pause_holds_time", S_PAUSE, 12'h003, 1'b0, 1'b0);
        press_start();
        expect_all("pause_start_door_open", S_PAUSE, 12'h003, 1'b0, 1'b0);
        door_closed = 1'b1;
        press_start();
        expect_all("resume", S_COOK, 12'h003, 1'b1, 1'b0);
        do_tick();
        do_tick();
        expect_all("resume_001", S_COOK, 12'h001, 1'b1, 1'b0);
        do_tick();
        expect_all("resume_done", S_DONE, 12'h000, 1'b0, 1'b1);
        press_stop();
        expect_all("done_stop_idle", S_IDLE, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_stop_pause_clear();
        load_time(4'd0, 4'd1, 4'd0);
        press_start();
        expect_all("stop_start", S_COOK, 12'h010, 1'b1, 1'b0);
        press_stop();
        expect_all("stop_pause", S_PAUSE, 12'h010, 1'b0, 1'b0);
        press_stop();
        expect_all("stop_clear", S_IDLE, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_clamp_door_open();
        load_time(4'd0, 4'd7, 4'd12);
        expect_all("clamp_059", S_SET, 12'h059, 1'b0, 1'b0);
        door_closed = 1'b0;
        press_start();
        expect_all("set_start_door_open", S_SET, 12'h059, 1'b0, 1'b0);
        door_closed = 1'b1;
        press_stop();
        expect_all("set_stop_idle", S_IDLE, 12'h000, 1'b0, 1'b0);
        load_time(4'd0, 4'd0, 4'd0);
        expect_all("load_zero_idle", S_IDLE, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_cook();
        load_time(4'd0, 4'd4, 4'd5);
        press_start();
        do_tick();
        do_tick();
        do_tick();
        expect_all("cook_042", S_COOK, 12'h042, 1'b1, 1'b0);
        load_time(4'd5, 4'd5, 4'd5);
        expect_all("cook_ignores_load", S_COOK, 12'h042, 1'b1, 1'b0);
        clearn = 1'b0;
        #1;
        expect_all("async_clear", S_IDLE, 12'h000, 1'b0, 1'b0);
        #1;
        clearn = 1'b1;
        step(1);
        expect_all("after_clear", S_IDLE, 12'h000, 1'b0, 1'b0);
    endtask

`ifdef MICROWAVE_QUICK_START_EN
    task automatic test_quick_start();
        press_start();
        expect_all("quick_idle_start", S_COOK, 12'h030, 1'b1, 1'b0);
        press_stop();
        press_stop();
        load_time(4'd9, 4'd4, 4'd5);
        press_start();
        press_start();
        expect_all("quick_saturate", S_COOK, 12'h959, 1'b1, 1'b0);
        press_stop();
        press_stop();
        load_time(4'd0, 4'd4, 4'd0);
        press_start();
        startn = 1'b0;
        step(1);
        startn = 1'b1;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        expect_all("quick_tick_add", S_COOK, 12'h109, 1'b1, 1'b0);
        press_stop();
        press_stop();
    endtask
`else
    task automatic test_quick_start();
        press_start();
        expect_all("idle_start_ignored", S_IDLE, 12'h000, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        clearn           = 1'b0;
        tick             = 1'b0;
        startn           = 1'b1;
        stopn            = 1'b1;
        door_closed      = 1'b1;
        loadn            = 1'b1;
        units_of_seconds = 4'd0;
        tens_of_seconds  = 4'd0;
        units_of_minutes = 4'd0;

        test_reset();
        test_full_countdown();
        test_door_pause();
        test_stop_pause_clear();
        test_clamp_door_open();
        test_reset_mid_cook();
        test_quick_start();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
